// File: rtl/ssp_tx_logic_if.sv
// FIFO-side and pad-side signals of the SSP transmit serializer.
// master: the serializer; slave: the FIFO/pad environment.
interface ssp_tx_logic_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] TxDATA;
    logic             EMPTY;
    logic             LOGICWRITE;
    logic             SSPCLKOUT;
    logic             SSPFSSOUT;
    logic             SSPTXD;
    logic             SSPOE_B;
    logic             BUSY;

    modport master (
        input  TxDATA, EMPTY,
        output LOGICWRITE, SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, BUSY
    );

    modport slave (
        output TxDATA, EMPTY,
        input  LOGICWRITE, SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, BUSY
    );
endinterface

// File: rtl/ssp_tx_logic.sv
// SSP transmit serializer: pops words from the TX FIFO and shifts them out
// MSB-first at PCLK/2 with a one-serial-clock frame sync ahead of each word.
module ssp_tx_logic #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  CLEAR,
    ssp_tx_logic_if.master        bus
);
    localparam int unsigned   CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        SHIFT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               clk_div_q;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   next_buf_q, next_buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               txd_q, txd_d;
    logic               fss_q, fss_d;
    logic               oe_b_q, oe_b_d;
    logic               lw_q, lw_d;
    logic               busy_q, busy_d;
    logic               tick_c;
    logic               last_bit_c;

    // Rising tick: this edge takes the serial clock from 0 to 1.
    assign tick_c     = ~clk_div_q;
    assign last_bit_c = (cnt_q == '0);

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            state_q    <= IDLE;
            clk_div_q  <= 1'b0;
            shift_q    <= '0;
            next_buf_q <= '0;
            cnt_q      <= '0;
            txd_q      <= 1'b0;
            fss_q      <= 1'b0;
            oe_b_q     <= 1'b1;
            lw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_div_q  <= ~clk_div_q;
            shift_q    <= shift_d;
            next_buf_q <= next_buf_d;
            cnt_q      <= cnt_d;
            txd_q      <= txd_d;
            fss_q      <= fss_d;
            oe_b_q     <= oe_b_d;
            lw_q       <= lw_d;
            busy_q     <= busy_d;
        end
    end

    // In SHIFT, fss_q is high only during the bit-0 period of a word whose
    // successor has already been popped into next_buf_q.
    always_comb begin
        state_d = state_q;
        if (tick_c) begin
            unique case (state_q)
                IDLE:    if (!bus.EMPTY) state_d = FRAME;
                FRAME:   state_d = SHIFT;
                SHIFT:   if (last_bit_c && !fss_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d    = shift_q;
        next_buf_d = next_buf_q;
        cnt_d      = cnt_q;
        txd_d      = txd_q;
        fss_d      = fss_q;
        oe_b_d     = oe_b_q;
        lw_d       = 1'b0;
        busy_d     = (state_d != IDLE);
        if (tick_c) begin
            unique case (state_q)
                IDLE: begin
                    txd_d  = 1'b0;
                    fss_d  = 1'b0;
                    oe_b_d = 1'b1;
                    if (!bus.EMPTY) begin
                        shift_d = bus.TxDATA;
                        lw_d    = 1'b1;
                        fss_d   = 1'b1;
                        oe_b_d  = 1'b0;
                    end
                end
                FRAME: begin
                    txd_d   = shift_q[WIDTH-1];
                    shift_d = shift_q << 1;
                    cnt_d   = CNT_TOP;
                    fss_d   = 1'b0;
                    oe_b_d  = 1'b0;
                end
                SHIFT: begin
                    if (!last_bit_c) begin
                        txd_d   = shift_q[WIDTH-1];
                        shift_d = shift_q << 1;
                        cnt_d   = cnt_q - CNT_W'(1);
                        // Entering bit 0: fetch the next word now so it follows with no gap.
                        if ((cnt_q == CNT_W'(1)) && !bus.EMPTY) begin
                            next_buf_d = bus.TxDATA;
                            lw_d       = 1'b1;
                            fss_d      = 1'b1;
                        end
                    end else if (fss_q) begin
                        txd_d   = next_buf_q[WIDTH-1];
                        shift_d = next_buf_q << 1;
                        cnt_d   = CNT_TOP;
                        fss_d   = 1'b0;
                    end else begin
                        txd_d  = 1'b0;
                        oe_b_d = 1'b1;
                    end
                end
                default: begin
                    txd_d  = 1'b0;
                    fss_d  = 1'b0;
                    oe_b_d = 1'b1;
                end
            endcase
        end
    end

    assign bus.LOGICWRITE = lw_q;
    assign bus.SSPCLKOUT  = clk_div_q;
    assign bus.SSPFSSOUT  = fss_q;
    assign bus.SSPTXD     = txd_q;
    assign bus.SSPOE_B    = oe_b_q;
    assign bus.BUSY       = busy_q;
endmodule

// File: tb/tb_ssp_tx_logic.sv
// Directed bench for ssp_tx_logic: a per-cycle vector table plus hand-written
// multi-cycle sequences driven from a small FIFO model.
module tb_ssp_tx_logic;
    logic PCLK;
    logic CLEAR;

    ssp_tx_logic_if #(.WIDTH(8)) bus ();

    ssp_tx_logic #(.WIDTH(8)) dut (
        .PCLK  (PCLK),
        .CLEAR (CLEAR),
        .bus   (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // {LOGICWRITE, SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, BUSY}
    logic [5:0] outs_c;
    assign outs_c = {bus.LOGICWRITE, bus.SSPCLKOUT, bus.SSPFSSOUT,
                     bus.SSPTXD, bus.SSPOE_B, bus.BUSY};

    typedef struct {
        logic       clr;
        logic       emp;
        logic [7:0] data;
        logic [5:0] exp;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] fifo[$];
    logic       pend;
    logic       hold_empty;
    int         tests;
    int         fails;

    task automatic add(input logic clr, input logic emp, input logic [7:0] data,
                       input logic [5:0] exp);
        vec_t v;
        v.clr = clr; v.emp = emp; v.data = data; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One PCLK with inputs taken from the FIFO model; the FIFO advances on the
    // edge after LOGICWRITE is seen high.
    task automatic step(input logic clr);
        CLEAR      = clr;
        bus.EMPTY  = hold_empty || (fifo.size() == 0);
        bus.TxDATA = (fifo.size() != 0) ? fifo[0] : 8'h00;
        @(posedge PCLK);
        #1;
        if (pend && fifo.size() != 0) void'(fifo.pop_front());
        pend = bus.LOGICWRITE;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  byte_v;
        logic [15:0] pair_v;
        logic [39:0] lw_a, fss_a, txd_a, oe_a, txd_e;
        int          cnt_lw, cnt_oe, cnt_txd, cnt_busy, tog;
        logic        prev_sclk;

        tests = 0; fails = 0; pend = 1'b0; hold_empty = 1'b0;
        CLEAR = 1'b1; bus.EMPTY = 1'b1; bus.TxDATA = 8'h00;

        // Reset, isolated 0xA5, then a reset in the middle of a word.
        add(1'b1, 1'b1, 8'h00, 6'b0_0_0_0_1_0);
        add(1'b0, 1'b0, 8'hA5, 6'b1_1_1_0_0_1);
        add(1'b0, 1'b1, 8'hA5, 6'b0_0_1_0_0_1);
        byte_v = 8'hA5;
        for (int j = 0; j < 8; j++) begin
            add(1'b0, 1'b1, 8'h00, {1'b0, 1'b1, 1'b0, byte_v[7-j], 1'b0, 1'b1});
            add(1'b0, 1'b1, 8'h00, {1'b0, 1'b0, 1'b0, byte_v[7-j], 1'b0, 1'b1});
        end
        add(1'b0, 1'b1, 8'h00, 6'b0_1_0_0_1_0);
        add(1'b0, 1'b1, 8'h00, 6'b0_0_0_0_1_0);
        add(1'b0, 1'b0, 8'hFF, 6'b1_1_1_0_0_1);
        add(1'b0, 1'b1, 8'hFF, 6'b0_0_1_0_0_1);
        add(1'b0, 1'b1, 8'hFF, 6'b0_1_0_1_0_1);
        add(1'b1, 1'b0, 8'hFF, 6'b0_0_0_0_1_0);
        add(1'b0, 1'b1, 8'h00, 6'b0_1_0_0_1_0);
        add(1'b0, 1'b1, 8'h00, 6'b0_0_0_0_1_0);

        for (int i = 0; i < vq.size(); i++) begin
            CLEAR      = vq[i].clr;
            bus.EMPTY  = vq[i].emp;
            bus.TxDATA = vq[i].data;
            @(posedge PCLK);
            #1;
            chk($sformatf("vec%0d", i), 64'(outs_c), 64'(vq[i].exp));
        end

        // Back-to-back 0x3C, 0xC3.
        fifo.delete(); pend = 1'b0;
        step(1'b1);
        fifo.push_back(8'h3C); fifo.push_back(8'hC3);
        for (int i = 0; i < 40; i++) begin
            step(1'b0);
            lw_a[i] = bus.LOGICWRITE; fss_a[i] = bus.SSPFSSOUT;
            txd_a[i] = bus.SSPTXD;    oe_a[i] = bus.SSPOE_B;
        end
        pair_v = 16'h3CC3;
        txd_e  = '0;
        for (int j = 0; j < 16; j++) begin
            txd_e[2+2*j] = pair_v[15-j];
            txd_e[3+2*j] = pair_v[15-j];
        end
        chk("b2b_lw",   64'(lw_a),  64'h00_0001_0001);
        chk("b2b_fss",  64'(fss_a), 64'h00_0003_0003);
        chk("b2b_oe_b", 64'(oe_a),  64'hFC_0000_0000);
        chk("b2b_txd",  64'(txd_a), 64'(txd_e));
        chk("b2b_fifo_drained", 64'(fifo.size()), 64'd0);

        // Empty idle for 50 cycles.
        step(1'b1);
        prev_sclk = bus.SSPCLKOUT;
        cnt_lw = 0; cnt_oe = 0; cnt_txd = 0; cnt_busy = 0; tog = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0);
            cnt_lw   += int'(bus.LOGICWRITE);
            cnt_oe   += int'(bus.SSPOE_B);
            cnt_txd  += int'(bus.SSPTXD);
            cnt_busy += int'(bus.BUSY);
            tog      += int'(bus.SSPCLKOUT != prev_sclk);
            prev_sclk = bus.SSPCLKOUT;
        end
        chk("idle_lw",      64'(cnt_lw),   64'd0);
        chk("idle_oe_b",    64'(cnt_oe),   64'd50);
        chk("idle_txd",     64'(cnt_txd),  64'd0);
        chk("idle_busy",    64'(cnt_busy), 64'd0);
        chk("idle_sclk_tg", 64'(tog),      64'd50);

        // Late data: EMPTY drops while the next edge is a falling one.
        for (int i = 0; i < 2 && bus.SSPCLKOUT != 1'b1; i++) step(1'b0);
        chk("late_phase", 64'(bus.SSPCLKOUT), 64'd1);
        fifo.push_back(8'h81);
        step(1'b0);
        chk("late_no_early_pop", 64'(bus.LOGICWRITE), 64'd0);
        step(1'b0);
        chk("late_pop_on_tick", 64'({bus.LOGICWRITE, bus.SSPFSSOUT, bus.SSPOE_B}), 64'b110);
        for (int i = 0; i < 17; i++) step(1'b0);
        chk("late_last_bit", 64'({bus.SSPTXD, bus.SSPOE_B, bus.BUSY}), 64'b101);
        step(1'b0);
        chk("late_done", 64'({bus.SSPOE_B, bus.BUSY}), 64'b10);

        // Reset during bit 3 of the second streamed word.
        fifo.delete(); pend = 1'b0;
        step(1'b1);
        fifo.push_back(8'h3C); fifo.push_back(8'hC3); fifo.push_back(8'hAA);
        cnt_lw = 0;
        for (int i = 0; i < 26; i++) begin
            step(1'b0);
            cnt_lw += int'(bus.LOGICWRITE);
        end
        chk("mid_pops_before", 64'(cnt_lw), 64'd2);
        chk("mid_bit4_c3", 64'({bus.SSPTXD, bus.SSPOE_B}), 64'b00);
        hold_empty = 1'b1;
        step(1'b1);
        chk("mid_reset_outs", 64'(outs_c), 64'b0_0_0_0_1_0);
        cnt_lw = 0; cnt_oe = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            cnt_lw += int'(bus.LOGICWRITE);
            cnt_oe += int'(bus.SSPOE_B);
        end
        chk("mid_hold_lw",   64'(cnt_lw), 64'd0);
        chk("mid_hold_oe_b", 64'(cnt_oe), 64'd4);
        hold_empty = 1'b0;
        step(1'b0);
        chk("mid_restart_frame", 64'(outs_c), 64'b1_1_1_0_0_1);
        step(1'b0);
        chk("mid_frame_hold", 64'(outs_c), 64'b0_0_1_0_0_1);
        step(1'b0);
        chk("mid_msb_aa", 64'(outs_c), 64'b0_1_0_1_0_1);
        step(1'b0); step(1'b0);
        chk("mid_bit6_aa", 64'({bus.SSPTXD, bus.SSPFSSOUT}), 64'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
